// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared types and helpers for the FIFO read-side pointer controller.
// Build option: define FIFO_RD_STATS_EN to add the pop/underflow statistics outputs.
package fifo_ctrl_pkg;

    localparam int unsigned STATS_WIDTH = 32;

    typedef enum logic [1:0] {
        S_INIT,
        S_RUN,
        S_ERR
    } rd_state_e;

    // Callers size the result back to their pointer width; high bits stay zero.
    function automatic logic [31:0] bin2gray(input logic [31:0] value);
        return value ^ (value >> 1);
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Consumer-side bus of the FIFO read controller.
// Build option: FIFO_RD_STATS_EN adds pop_cnt_o / underflow_cnt_o.
interface fifo_rd_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 4
);
    import fifo_ctrl_pkg::*;

    logic [ADDR_WIDTH:0]   wr_ptr_gray_i;
    logic                  pop_i;
    logic                  flush_i;
    logic                  rd_en_o;
    logic [ADDR_WIDTH-1:0] rd_addr_o;
    logic [ADDR_WIDTH:0]   rd_ptr_gray_o;
    logic                  empty_o;
    logic [ADDR_WIDTH:0]   count_o;
    logic                  err_o;
`ifdef FIFO_RD_STATS_EN
    logic [STATS_WIDTH-1:0] pop_cnt_o;
    logic [STATS_WIDTH-1:0] underflow_cnt_o;
`endif

    modport master (
        output wr_ptr_gray_i, pop_i, flush_i,
        input  rd_en_o, rd_addr_o, rd_ptr_gray_o, empty_o, count_o, err_o
`ifdef FIFO_RD_STATS_EN
        , input pop_cnt_o, underflow_cnt_o
`endif
    );

    modport slave (
        input  wr_ptr_gray_i, pop_i, flush_i,
        output rd_en_o, rd_addr_o, rd_ptr_gray_o, empty_o, count_o, err_o
`ifdef FIFO_RD_STATS_EN
        , output pop_cnt_o, underflow_cnt_o
`endif
    );

endinterface

// File: rtl/fifo_rd_ctrl_gray_2_bin.sv
// Gray-to-binary decoder: each binary bit is the XOR of all Gray bits at or above it.
module gray_2_bin #(
    parameter int unsigned WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    always_comb begin
        bin = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer controller for a dual-clock FIFO (empty, fill count, RAM read strobe).
// Build option: FIFO_RD_STATS_EN adds saturating accepted-pop and underflow counters.
module fifo_rd_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    fifo_rd_ctrl_if.slave bus
);

    localparam int unsigned PTR_W = ADDR_WIDTH + 1;
    localparam logic [PTR_W-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    rd_state_e         state_q, state_d;
    logic [PTR_W-1:0]  rd_bin_q, rd_bin_d;
    logic [PTR_W-1:0]  rd_gray_q;
    logic [PTR_W-1:0]  wr_gray_q;
    logic [PTR_W-1:0]  wr_bin;
    logic [PTR_W-1:0]  count_raw;
    logic [PTR_W-1:0]  count;
    logic              overflow;
    logic              empty_raw;
    logic              empty;
    logic              rd_en;
    logic              err;
    logic              underflow_evt;

    gray_2_bin #(.WIDTH(PTR_W)) u_wr_g2b (
        .gray (wr_gray_q),
        .bin  (wr_bin)
    );

    // A corrupted (over-full) distance is reported in the same cycle it becomes
    // visible, and stays reported once the FSM has latched it into S_ERR.
    always_comb begin
        count_raw     = wr_bin - rd_bin_q;
        overflow      = count_raw > DEPTH;
        empty_raw     = (count_raw == '0);
        state_d       = state_q;
        rd_bin_d      = rd_bin_q;
        rd_en         = 1'b0;
        err           = 1'b0;
        empty         = 1'b1;
        count         = '0;
        underflow_evt = 1'b0;
        case (state_q)
            S_INIT: state_d = S_RUN;
            S_RUN: begin
                if (overflow) begin
                    state_d = S_ERR;
                    err     = 1'b1;
                end else begin
                    empty         = empty_raw;
                    count         = count_raw;
                    rd_en         = bus.pop_i & ~empty_raw & ~bus.flush_i;
                    underflow_evt = bus.pop_i & empty_raw & ~bus.flush_i;
                    if (bus.flush_i) begin
                        rd_bin_d = wr_bin;
                    end else if (rd_en) begin
                        rd_bin_d = rd_bin_q + 1'b1;
                    end
                end
            end
            S_ERR: err = 1'b1;
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_INIT;
            rd_bin_q  <= '0;
            rd_gray_q <= '0;
            wr_gray_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_bin_q  <= rd_bin_d;
            rd_gray_q <= PTR_W'(bin2gray(32'(rd_bin_d)));
            wr_gray_q <= bus.wr_ptr_gray_i;
        end
    end

    assign bus.rd_en_o       = rd_en;
    assign bus.rd_addr_o     = rd_bin_q[ADDR_WIDTH-1:0];
    assign bus.rd_ptr_gray_o = rd_gray_q;
    assign bus.empty_o       = empty;
    assign bus.count_o       = count;
    assign bus.err_o         = err;

`ifdef FIFO_RD_STATS_EN
    logic [STATS_WIDTH-1:0] pop_cnt_q;
    logic [STATS_WIDTH-1:0] underflow_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pop_cnt_q       <= '0;
            underflow_cnt_q <= '0;
        end else begin
            if (rd_en && pop_cnt_q != '1) begin
                pop_cnt_q <= pop_cnt_q + 1'b1;
            end
            if (underflow_evt && underflow_cnt_q != '1) begin
                underflow_cnt_q <= underflow_cnt_q + 1'b1;
            end
        end
    end

    assign bus.pop_cnt_o       = pop_cnt_q;
    assign bus.underflow_cnt_o = underflow_cnt_q;
`else
    logic unused_underflow;
    assign unused_underflow = underflow_evt;
`endif

endmodule
